// File: rtl/debounce_edge.sv
// debounce_edge: two-flop synchroniser plus stability-count filter for a
// bouncy single-bit input. Produces a clean registered level with its
// complement, one-cycle rise/fall pulses and a busy flag while a candidate
// level change is being qualified.
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic doutbar,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Final count value: the sample that completes qualification arrives while
  // cnt holds STABLE_CYCLES-1, so the counter never needs to go higher.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; only s2 is allowed to reach the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Qualification FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE_LOW;
      cnt     <= '0;
      dout    <= 1'b0;
      doutbar <= 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s2) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2) begin
            // Bounced back before qualifying: drop the candidate silently.
            state <= IDLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE_HIGH;
            cnt     <= '0;
            busy    <= 1'b0;
            dout    <= 1'b1;
            doutbar <= 1'b0;
            rise    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s2) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (s2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            busy    <= 1'b0;
            dout    <= 1'b0;
            doutbar <= 1'b1;
            fall    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE_LOW;
          cnt     <= '0;
          busy    <= 1'b0;
          dout    <= 1'b0;
          doutbar <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: directed scenarios with fixed
// expectations plus a randomized run against a run-length reference model.
module tb_debounce_edge;

  localparam int SC = 4;

  logic clk;
  logic rst;
  logic din;
  logic dout, doutbar, rise, fall, busy;

  int n_chk;
  int n_fail;

  debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .dout    (dout),
    .doutbar (doutbar),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the filtered level flips once SC consecutive
  // synchronised samples (din delayed two edges) disagree with it.
  bit pipe[$];
  bit m_dout, m_rise, m_fall;
  int m_run;
  bit s2v;

  initial begin
    pipe   = '{1'b0, 1'b0};
    m_dout = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = 0;
  end

  // Advance the model once per clock edge, same inputs as the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      pipe   = '{1'b0, 1'b0};
      m_dout = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_run  = 0;
    end else begin
      s2v = pipe.pop_front();
      pipe.push_back(din);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s2v != m_dout) m_run = m_run + 1;
      else               m_run = 0;
      if (m_run == SC) begin
        m_dout = ~m_dout;
        m_rise = m_dout;
        m_fall = ~m_dout;
        m_run  = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({dout, doutbar, rise, fall, busy} !== 5'b01000) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got {d,db,r,f,b}=%b want 01000", i,
                 {dout, doutbar, rise, fall, busy});
      end
    end
    rst = 1'b0;
    din = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_clean_rise();
    logic [4:0] exp;
    din = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp = {e >= SC + 1, e < SC + 1, e == SC + 1, 1'b0, (e >= 2) && (e < SC + 1)};
      n_chk++;
      if ({dout, doutbar, rise, fall, busy} !== exp) begin
        n_fail++;
        $display("FAIL clean_rise edge=%0d got %b want %b", e,
                 {dout, doutbar, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_clean_fall();
    logic [4:0] exp;
    din = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp = {e < SC + 1, e >= SC + 1, 1'b0, e == SC + 1, (e >= 2) && (e < SC + 1)};
      n_chk++;
      if ({dout, doutbar, rise, fall, busy} !== exp) begin
        n_fail++;
        $display("FAIL clean_fall edge=%0d got %b want %b", e,
                 {dout, doutbar, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] exp;
    for (int e = 0; e < 12; e++) begin
      din = (e < SC - 1);
      tick();
      exp = {1'b0, 1'b1, 1'b0, 1'b0, (e >= 2) && (e <= SC)};
      n_chk++;
      if ({dout, doutbar, rise, fall, busy} !== exp) begin
        n_fail++;
        $display("FAIL glitch edge=%0d got %b want %b", e,
                 {dout, doutbar, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[9];
    int rises;
    pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rises = 0;
    for (int e = 0; e < 16; e++) begin
      din = (e < 9) ? pat[e] : 1'b1;
      tick();
      if (rise === 1'b1) rises++;
      n_chk++;
      if ({dout, rise, fall} !== {e >= 5 + SC + 1, e == 5 + SC + 1, 1'b0}) begin
        n_fail++;
        $display("FAIL bounce edge=%0d got {d,r,f}=%b want %b", e, {dout, rise, fall},
                 {e >= 5 + SC + 1, e == 5 + SC + 1, 1'b0});
      end
    end
    n_chk++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_count got %0d rise pulses want 1", rises);
    end
    // Return to the low level for the next scenario.
    din = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp;
    din = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    n_chk++;
    if ({dout, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_pre got {d,b}=%b want 01", {dout, busy});
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if ({dout, doutbar, rise, fall, busy} !== 5'b01000) begin
      n_fail++;
      $display("FAIL reset_mid_rst got %b want 01000", {dout, doutbar, rise, fall, busy});
    end
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp = {e >= SC + 1, e < SC + 1, e == SC + 1, 1'b0, (e >= 2) && (e < SC + 1)};
      n_chk++;
      if ({dout, doutbar, rise, fall, busy} !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_release edge=%0d got %b want %b", e,
                 {dout, doutbar, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_random();
    int run_left;
    logic [4:0] exp;
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        din      = $urandom_range(0, 1);
        run_left = $urandom_range(1, 2 * SC + 2);
      end
      run_left--;
      rst = ($urandom_range(0, 199) == 0);
      tick();
      exp = {m_dout, ~m_dout, m_rise, m_fall, m_run != 0};
      n_chk++;
      if ({dout, doutbar, rise, fall, busy} !== exp) begin
        n_fail++;
        $display("FAIL random cyc=%0d got {d,db,r,f,b}=%b want %b", c,
                 {dout, doutbar, rise, fall, busy}, exp);
      end
      n_chk++;
      if ((rise & fall) !== 1'b0) begin
        n_fail++;
        $display("FAIL random_both_pulses cyc=%0d got r=%b f=%b want not both", c, rise, fall);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    din    = 1'b0;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
